// File: rtl/qa_umf_channel_mux.sv
// N-channel UMF mux/demux in front of the QuickAssist driver.
// TX: per-channel FIFOs drained round-robin. RX: channel-id field routes each driver word to a per-channel register.
module qa_umf_channel_mux #(
  parameter  int N_CHAN        = 4,
  parameter  int UMF_WIDTH     = 128,
  parameter  int CHAN_ID_WIDTH = 4,
  parameter  int FIFO_DEPTH    = 4,
  localparam int PAYLOAD_WIDTH = UMF_WIDTH - CHAN_ID_WIDTH
) (
  input  logic                            vl_clk_LPdomain_32ui,
  input  logic                            ffs_vl_LP32ui_lp2sy_SoftReset_n,
  input  logic [N_CHAN*PAYLOAD_WIDTH-1:0] cl_tx_data,
  input  logic [N_CHAN-1:0]               cl_tx_valid,
  output logic [N_CHAN-1:0]               cl_tx_rdy,
  output logic [N_CHAN*PAYLOAD_WIDTH-1:0] cl_rx_data,
  output logic [N_CHAN-1:0]               cl_rx_valid,
  input  logic [N_CHAN-1:0]               cl_rx_enable,
  output logic [UMF_WIDTH-1:0]            drv_tx_data,
  output logic                            drv_tx_enable,
  input  logic                            drv_tx_rdy,
  input  logic [UMF_WIDTH-1:0]            drv_rx_data,
  input  logic                            drv_rx_rdy,
  output logic                            drv_rx_enable,
  output logic [15:0]                     err_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]              PTR_ONE  = (AW+1)'(1);
  localparam logic [CHAN_ID_WIDTH-1:0] ID_ONE   = CHAN_ID_WIDTH'(1);
  localparam logic [CHAN_ID_WIDTH-1:0] LAST_ID  = CHAN_ID_WIDTH'(N_CHAN - 1);
  localparam logic [CHAN_ID_WIDTH:0]   ID_LIMIT = (CHAN_ID_WIDTH+1)'(N_CHAN);

  typedef logic [PAYLOAD_WIDTH-1:0] payload_t;

  logic clk, rst_n;
  assign clk   = vl_clk_LPdomain_32ui;
  assign rst_n = ffs_vl_LP32ui_lp2sy_SoftReset_n;

  payload_t                 mem_q    [N_CHAN][FIFO_DEPTH];
  payload_t                 mem_d    [N_CHAN][FIFO_DEPTH];
  logic [AW:0]              wr_ptr_q [N_CHAN];
  logic [AW:0]              wr_ptr_d [N_CHAN];
  logic [AW:0]              rd_ptr_q [N_CHAN];
  logic [AW:0]              rd_ptr_d [N_CHAN];
  logic [CHAN_ID_WIDTH-1:0] rr_q, rr_d;
  payload_t                 rx_data_q [N_CHAN];
  payload_t                 rx_data_d [N_CHAN];
  logic [N_CHAN-1:0]        rx_valid_q, rx_valid_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;

  logic [N_CHAN-1:0]        empty, full;
  logic                     any_elig, tx_issue;
  logic [CHAN_ID_WIDTH-1:0] grant;
  payload_t                 head;

  logic [CHAN_ID_WIDTH-1:0] rx_id;
  payload_t                 rx_payload;
  logic                     rx_id_ok, rx_blocked;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  // Rotating priority: channels at or above the pointer first, then the wrapped-around remainder.
  always_comb begin
    any_elig = 1'b0;
    grant    = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (!any_elig && !empty[i] && (i[CHAN_ID_WIDTH-1:0] >= rr_q)) begin
        any_elig = 1'b1;
        grant    = i[CHAN_ID_WIDTH-1:0];
      end
    end
    for (int i = 0; i < N_CHAN; i++) begin
      if (!any_elig && !empty[i] && (i[CHAN_ID_WIDTH-1:0] < rr_q)) begin
        any_elig = 1'b1;
        grant    = i[CHAN_ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (grant == i[CHAN_ID_WIDTH-1:0]) head = mem_q[i][rd_ptr_q[i][AW-1:0]];
    end
  end

  assign tx_issue      = drv_tx_rdy & any_elig;
  assign drv_tx_enable = tx_issue;
  assign drv_tx_data   = {grant, head};
  assign cl_tx_rdy     = ~full;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_d     = rr_q;
    for (int i = 0; i < N_CHAN; i++) begin
      if (cl_tx_valid[i] && !full[i]) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = cl_tx_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
      end
      if (tx_issue && (grant == i[CHAN_ID_WIDTH-1:0])) rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
    end
    if (tx_issue) rr_d = (grant == LAST_ID) ? '0 : grant + ID_ONE;
  end

  assign rx_id      = drv_rx_data[UMF_WIDTH-1 -: CHAN_ID_WIDTH];
  assign rx_payload = drv_rx_data[PAYLOAD_WIDTH-1:0];
  assign rx_id_ok   = ({1'b0, rx_id} < ID_LIMIT);

  // Only an occupied, unconsumed target register stalls the driver; bad ids always drain.
  always_comb begin
    rx_blocked = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if ((rx_id == i[CHAN_ID_WIDTH-1:0]) && rx_valid_q[i] && !cl_rx_enable[i]) rx_blocked = 1'b1;
    end
  end

  assign drv_rx_enable = drv_rx_rdy & ~rx_blocked;

  always_comb begin
    rx_valid_d = rx_valid_q & ~cl_rx_enable;
    rx_data_d  = rx_data_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < N_CHAN; i++) begin
      if (drv_rx_enable && rx_id_ok && (rx_id == i[CHAN_ID_WIDTH-1:0])) begin
        rx_valid_d[i] = 1'b1;
        rx_data_d[i]  = rx_payload;
      end
    end
    if (drv_rx_enable && !rx_id_ok && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_comb begin
    cl_rx_data = '0;
    for (int i = 0; i < N_CHAN; i++) cl_rx_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = rx_data_q[i];
  end

  assign cl_rx_valid  = rx_valid_q;
  assign err_drop_cnt = drop_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      rr_q       <= '0;
      rx_data_q  <= '{default: '0};
      rx_valid_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rr_q       <= rr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the cleared pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_qa_umf_channel_mux.sv
// Self-checking bench for qa_umf_channel_mux: directed scenarios plus random traffic,
// all compared against a queue-based transaction model of the mux.
module tb_qa_umf_channel_mux;

  localparam int N     = 4;
  localparam int UW    = 128;
  localparam int PW    = 124;
  localparam int DEPTH = 4;
  localparam int CW    = 154;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*PW-1:0]   cl_tx_data;
  logic [N-1:0]      cl_tx_valid;
  logic [N-1:0]      cl_tx_rdy;
  logic [N*PW-1:0]   cl_rx_data;
  logic [N-1:0]      cl_rx_valid;
  logic [N-1:0]      cl_rx_enable;
  logic [UW-1:0]     drv_tx_data;
  logic              drv_tx_enable;
  logic              drv_tx_rdy;
  logic [UW-1:0]     drv_rx_data;
  logic              drv_rx_rdy;
  logic              drv_rx_enable;
  logic [15:0]       err_drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qa_umf_channel_mux dut (
    .vl_clk_LPdomain_32ui            (clk),
    .ffs_vl_LP32ui_lp2sy_SoftReset_n (rst_n),
    .cl_tx_data                      (cl_tx_data),
    .cl_tx_valid                     (cl_tx_valid),
    .cl_tx_rdy                       (cl_tx_rdy),
    .cl_rx_data                      (cl_rx_data),
    .cl_rx_valid                     (cl_rx_valid),
    .cl_rx_enable                    (cl_rx_enable),
    .drv_tx_data                     (drv_tx_data),
    .drv_tx_enable                   (drv_tx_enable),
    .drv_tx_rdy                      (drv_tx_rdy),
    .drv_rx_data                     (drv_rx_data),
    .drv_rx_rdy                      (drv_rx_rdy),
    .drv_rx_enable                   (drv_rx_enable),
    .err_drop_cnt                    (err_drop_cnt)
  );

  // ---------------- transaction model ----------------
  logic [PW-1:0] txq [N][$];
  int            rr;
  bit            rxv [N];
  logic [PW-1:0] rxd [N];
  int            cnt;

  logic [N-1:0]  e_tx_rdy;
  logic          e_tx_en;
  int            e_grant;
  logic [UW-1:0] e_tx_data;
  logic          e_rx_en;
  int            e_id;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      rxv[i] = 1'b0;
      rxd[i] = '0;
    end
    rr  = 0;
    cnt = 0;
  endtask

  task automatic model_eval();
    e_id = int'(drv_rx_data[UW-1 -: 4]);
    for (int i = 0; i < N; i++) e_tx_rdy[i] = (txq[i].size() < DEPTH);
    e_tx_en = 1'b0;
    e_grant = 0;
    if (drv_tx_rdy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (!e_tx_en && txq[c].size() > 0) begin
          e_tx_en = 1'b1;
          e_grant = c;
        end
      end
    end
    e_tx_data = e_tx_en ? {4'(e_grant), txq[e_grant][0]} : '0;
    e_rx_en = 1'b0;
    if (drv_rx_rdy) begin
      if (e_id >= N) e_rx_en = 1'b1;
      else e_rx_en = !rxv[e_id] || cl_rx_enable[e_id];
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (e_tx_en) begin
        void'(txq[e_grant].pop_front());
        rr = (e_grant + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (cl_tx_valid[i] && e_tx_rdy[i]) txq[i].push_back(cl_tx_data[i*PW +: PW]);
      for (int i = 0; i < N; i++) if (cl_rx_enable[i]) rxv[i] = 1'b0;
      if (e_rx_en) begin
        if (e_id < N) begin
          rxv[e_id] = 1'b1;
          rxd[e_id] = drv_rx_data[PW-1:0];
        end else if (cnt < 65535) begin
          cnt++;
        end
      end
    end
  endtask

  function automatic logic [CW-1:0] ctl_obs();
    return {cl_tx_rdy, drv_tx_enable, (drv_tx_enable ? drv_tx_data : {UW{1'b0}}),
            drv_rx_enable, cl_rx_valid, err_drop_cnt};
  endfunction

  function automatic logic [CW-1:0] ctl_exp();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = rxv[i];
    return {e_tx_rdy, e_tx_en, e_tx_data, e_rx_en, v, 16'(cnt)};
  endfunction

  // Payload lanes are only meaningful while the model says the lane is valid.
  function automatic logic [N*PW-1:0] rxd_obs();
    logic [N*PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (rxv[i]) r[i*PW +: PW] = cl_rx_data[i*PW +: PW];
    return r;
  endfunction

  function automatic logic [N*PW-1:0] rxd_exp();
    logic [N*PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (rxv[i]) r[i*PW +: PW] = rxd[i];
    return r;
  endfunction

  function automatic logic [UW-1:0] rx_word(input int id, input logic [PW-1:0] p);
    return {4'(id), p};
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  task automatic idle_inputs();
    cl_tx_data   = '0;
    cl_tx_valid  = '0;
    cl_rx_enable = '0;
    drv_tx_rdy   = 1'b0;
    drv_rx_data  = '0;
    drv_rx_rdy   = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) begin
      @(posedge clk);
      model_commit();
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 model_eval();
    n_cmp++;
    if (cl_tx_rdy !== 4'b1111 || drv_tx_enable !== 1'b0 || cl_rx_valid !== 4'b0000 ||
        err_drop_cnt !== 16'h0000 || drv_rx_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: tx_rdy=%b tx_en=%b rx_valid=%b drops=%h rx_en=%b, want 1111 0 0000 0000 0",
               cl_tx_rdy, drv_tx_enable, cl_rx_valid, err_drop_cnt, drv_rx_enable);
    end
    n_cmp++;
    if (cl_rx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h want 0", cl_rx_data);
    end
    @(posedge clk);
    model_commit();
  endtask

  task automatic test_back_to_back();
    int ids[$];
    logic [PW-1:0] pays[$];
    int first_cyc, last_cyc;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      idle_inputs();
      drv_tx_rdy = 1'b1;
      if (cyc < 3) begin
        cl_tx_valid = 4'hF;
        for (int ch = 0; ch < N; ch++) cl_tx_data[ch*PW +: PW] = PW'(ch*16 + cyc);
      end
      #1 model_eval();
      n_cmp++;
      if (ctl_obs() !== ctl_exp()) begin
        n_fail++;
        $display("FAIL b2b_ctl cyc %0d: got %h want %h", cyc, ctl_obs(), ctl_exp());
      end
      if (drv_tx_enable === 1'b1) begin
        ids.push_back(int'(drv_tx_data[UW-1 -: 4]));
        pays.push_back(drv_tx_data[PW-1:0]);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      @(posedge clk);
      model_commit();
    end
    n_cmp++;
    if (ids.size() != 12 || (last_cyc - first_cyc) != 11) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words over span %0d, want 12 over 11", ids.size(), last_cyc - first_cyc);
    end
    for (int j = 0; j < ids.size() && j < 12; j++) begin
      n_cmp++;
      if (ids[j] != j % N || pays[j] !== PW'((j % N)*16 + j / N)) begin
        n_fail++;
        $display("FAIL b2b_order word %0d: got id %0d payload %h, want id %0d payload %h",
                 j, ids[j], pays[j], j % N, PW'((j % N)*16 + j / N));
      end
    end
  endtask

  task automatic test_fifo_full();
    int n;
    int got[$];
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      idle_inputs();
      drv_tx_rdy = (cyc >= 6);
      if (n < 5) begin
        cl_tx_valid[2] = 1'b1;
        cl_tx_data[2*PW +: PW] = PW'(32'h200 + n);
      end
      #1 model_eval();
      n_cmp++;
      if (ctl_obs() !== ctl_exp()) begin
        n_fail++;
        $display("FAIL full_ctl cyc %0d: got %h want %h", cyc, ctl_obs(), ctl_exp());
      end
      if (cyc == 4 || cyc == 6) begin
        n_cmp++;
        if (cl_tx_rdy[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL full_rdy cyc %0d: cl_tx_rdy[2]=%b want 0", cyc, cl_tx_rdy[2]);
        end
      end
      if (drv_tx_enable === 1'b1) begin
        n_cmp++;
        if (drv_tx_data !== {4'd2, PW'(32'h200 + got.size())}) begin
          n_fail++;
          $display("FAIL full_drain word %0d: got %h want id 2 payload %h", got.size(), drv_tx_data,
                   32'h200 + got.size());
        end
        got.push_back(1);
      end
      @(posedge clk);
      if (cl_tx_valid[2] && e_tx_rdy[2]) n++;
      model_commit();
    end
    n_cmp++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL full_count: got %0d words want 5", got.size());
    end
  endtask

  task automatic test_rx_hol();
    logic [UW-1:0] wq[$];
    logic [PW-1:0] pa, pb, pc;
    pa = rand_payload();
    pb = rand_payload();
    pc = rand_payload();
    wq.push_back(rx_word(1, pa));
    wq.push_back(rx_word(1, pb));
    wq.push_back(rx_word(3, pc));
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      idle_inputs();
      drv_rx_rdy  = (wq.size() > 0);
      drv_rx_data = (wq.size() > 0) ? wq[0] : '0;
      cl_rx_enable = (cyc == 5) ? 4'b0010 : ((cyc >= 8) ? 4'hF : 4'h0);
      #1 model_eval();
      n_cmp++;
      if (ctl_obs() !== ctl_exp() || rxd_obs() !== rxd_exp()) begin
        n_fail++;
        $display("FAIL hol_state cyc %0d: got %h/%h want %h/%h", cyc, ctl_obs(), rxd_obs(), ctl_exp(), rxd_exp());
      end
      if (cyc >= 1 && cyc <= 6) begin
        n_cmp++;
        if (drv_rx_enable !== (cyc >= 5)) begin
          n_fail++;
          $display("FAIL hol_stall cyc %0d: drv_rx_enable=%b want %b", cyc, drv_rx_enable, cyc >= 5);
        end
      end
      if (cyc == 1 || cyc == 6) begin
        n_cmp++;
        if (cl_rx_valid[1] !== 1'b1 || cl_rx_data[PW +: PW] !== ((cyc == 1) ? pa : pb)) begin
          n_fail++;
          $display("FAIL hol_ch1 cyc %0d: valid=%b data=%h want 1 %h", cyc, cl_rx_valid[1],
                   cl_rx_data[PW +: PW], (cyc == 1) ? pa : pb);
        end
      end
      @(posedge clk);
      if (e_rx_en) void'(wq.pop_front());
      model_commit();
    end
  endtask

  task automatic test_bad_id();
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      idle_inputs();
      if (cyc == 0) begin
        drv_rx_rdy  = 1'b1;
        drv_rx_data = rx_word(7, rand_payload());
      end
      #1 model_eval();
      n_cmp++;
      if (ctl_obs() !== ctl_exp()) begin
        n_fail++;
        $display("FAIL bad_id_ctl cyc %0d: got %h want %h", cyc, ctl_obs(), ctl_exp());
      end
      if (cyc == 1) begin
        n_cmp++;
        if (err_drop_cnt !== 16'd1 || cl_rx_valid !== 4'b0000) begin
          n_fail++;
          $display("FAIL bad_id_drop: drops=%h valid=%b want 0001 0000", err_drop_cnt, cl_rx_valid);
        end
      end
      @(posedge clk);
      model_commit();
    end
    for (int k = 0; k < 65536; k++) begin
      @(negedge clk);
      drv_rx_rdy  = 1'b1;
      drv_rx_data = rx_word(4 + (k % 12), '0);
      #1 model_eval();
      @(posedge clk);
      model_commit();
    end
    @(negedge clk);
    idle_inputs();
    #1 model_eval();
    n_cmp++;
    if (err_drop_cnt !== 16'hFFFF || ctl_obs() !== ctl_exp()) begin
      n_fail++;
      $display("FAIL bad_id_saturate: drops=%h want ffff (ctl got %h want %h)", err_drop_cnt, ctl_obs(), ctl_exp());
    end
    @(posedge clk);
    model_commit();
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      idle_inputs();
      rst_n = (cyc != 3);
      if (cyc < 2) begin
        cl_tx_valid[0] = 1'b1;
        cl_tx_data[0 +: PW] = rand_payload();
      end
      if (cyc == 0) begin
        drv_rx_rdy  = 1'b1;
        drv_rx_data = rx_word(3, rand_payload());
      end
      if (cyc >= 4) drv_tx_rdy = 1'b1;
      if (cyc == 5) begin
        cl_tx_valid = 4'b1001;
        cl_tx_data[0 +: PW]    = PW'(32'hA0);
        cl_tx_data[3*PW +: PW] = PW'(32'hA3);
      end
      #1 model_eval();
      if (cyc != 3) begin
        n_cmp++;
        if (ctl_obs() !== ctl_exp() || rxd_obs() !== rxd_exp()) begin
          n_fail++;
          $display("FAIL rst_mid_state cyc %0d: got %h want %h", cyc, ctl_obs(), ctl_exp());
        end
      end
      if (cyc == 4) begin
        n_cmp++;
        if (cl_tx_rdy !== 4'hF || drv_tx_enable !== 1'b0 || cl_rx_valid !== 4'h0 || err_drop_cnt !== 16'h0) begin
          n_fail++;
          $display("FAIL rst_mid_clear: tx_rdy=%b tx_en=%b rx_valid=%b drops=%h want 1111 0 0000 0000",
                   cl_tx_rdy, drv_tx_enable, cl_rx_valid, err_drop_cnt);
        end
      end
      if (cyc == 6 || cyc == 7) begin
        n_cmp++;
        if (drv_tx_enable !== 1'b1 || drv_tx_data !== ((cyc == 6) ? {4'd0, PW'(32'hA0)} : {4'd3, PW'(32'hA3)})) begin
          n_fail++;
          $display("FAIL rst_mid_rr cyc %0d: en=%b data=%h want channel %0d first", cyc, drv_tx_enable,
                   drv_tx_data, (cyc == 6) ? 0 : 3);
        end
      end
      @(posedge clk);
      model_commit();
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      cl_tx_valid = 4'($urandom);
      for (int ch = 0; ch < N; ch++) cl_tx_data[ch*PW +: PW] = rand_payload();
      drv_tx_rdy   = ($urandom_range(0, 3) != 0);
      drv_rx_rdy   = ($urandom_range(0, 2) != 0);
      drv_rx_data  = rx_word($urandom_range(0, 5), rand_payload());
      cl_rx_enable = 4'($urandom);
      #1 model_eval();
      n_cmp++;
      if (ctl_obs() !== ctl_exp() || rxd_obs() !== rxd_exp()) begin
        n_fail++;
        $display("FAIL random cyc %0d: ctl got %h want %h", cyc, ctl_obs(), ctl_exp());
      end
      @(posedge clk);
      model_commit();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_fifo_full();
    test_rx_hol();
    test_bad_id();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qa_umf_channel_mux.md
Name: qa_umf_channel_mux

Overview:
- Parametrised successor to the single-channel CCI client interface.
- Multiplexes N_CHAN independent client UMF streams onto the one UMF stream of the QuickAssist driver, and demultiplexes the driver RX stream back to the clients.
- Sits between the LEAP physical-channel clients and qa_driver's rx_*/tx_* ports.
- TX uses per-channel FIFOs with round-robin arbitration. RX uses per-channel output registers, and a channel-id field in each driver word selects the target channel.

Parameters:
- N_CHAN, 4, number of client channels (1..16).
- UMF_WIDTH, 128, driver-side word width.
- CHAN_ID_WIDTH, 4, channel-id field width; must satisfy 2**CHAN_ID_WIDTH >= N_CHAN.
- FIFO_DEPTH, 4, per-channel TX FIFO entries; power of 2, >= 2.
- PAYLOAD_WIDTH, UMF_WIDTH-CHAN_ID_WIDTH, client payload width (derived; not overridden).

Ports:
- vl_clk_LPdomain_32ui  in  1  sole clock; all logic on rising edge.
- ffs_vl_LP32ui_lp2sy_SoftReset_n  in  1  synchronous, active-low reset.
- cl_tx_data  in  N_CHAN*PAYLOAD_WIDTH  client TX payloads; channel i occupies slice i.
- cl_tx_valid  in  N_CHAN  client word offered.
- cl_tx_rdy  out  N_CHAN  channel FIFO can accept.
- cl_rx_data  out  N_CHAN*PAYLOAD_WIDTH  client RX payloads.
- cl_rx_valid  out  N_CHAN  RX register holds a word.
- cl_rx_enable  in  N_CHAN  client consumes the word.
- drv_tx_data  out  UMF_WIDTH  {chan_id, payload} to driver tx_data.
- drv_tx_enable  out  1  enqueue to driver.
- drv_tx_rdy  in  1  driver tx_rdy.
- drv_rx_data  in  UMF_WIDTH  driver rx_data.
- drv_rx_rdy  in  1  driver rx_rdy (word available).
- drv_rx_enable  out  1  dequeue from driver.
- err_drop_cnt  out  16  saturating count of RX words carrying an invalid channel id.

Behaviour:
- Reset, sampled on a clock edge while SoftReset_n=0:
  - All FIFOs emptied; cl_tx_rdy=all 1 from the first cycle after release.
  - cl_rx_valid=0, cl_rx_data=0.
  - drv_tx_enable=0, drv_rx_enable=0.
  - err_drop_cnt=0; round-robin pointer=0.
- Reset mid-operation: all buffered words are discarded; no partial transfers complete.
- TX enqueue:
  - A transfer occurs on channel i when cl_tx_valid[i] & cl_tx_rdy[i].
  - cl_tx_rdy[i] = !full[i], with no same-cycle bypass: a full FIFO rejects even when it dequeues that cycle.
  - An enqueued word is eligible for arbitration the next cycle, so minimum latency from client to drv_tx_enable is 1 cycle.
- TX arbitration:
  - Eligible = FIFO non-empty. The search starts at pointer p and wraps modulo N_CHAN.
  - drv_tx_enable = drv_tx_rdy & (any eligible). This is combinational from registered FIFO state and drv_tx_rdy.
  - drv_tx_data = {grant index zero-extended to CHAN_ID_WIDTH, head payload of the granted channel}.
  - On issue, the granted FIFO pops and p <= (grant+1) mod N_CHAN. With no issue, p holds.
  - Sustained throughput is 1 word/cycle. Per-channel order is preserved.
  - Fairness: with all channels backlogged, grants follow 0,1,...,N_CHAN-1,0,...
- RX demux:
  - id = drv_rx_data[UMF_WIDTH-1 -: CHAN_ID_WIDTH].
  - drv_rx_enable = drv_rx_rdy & (id>=N_CHAN | !cl_rx_valid[id] | cl_rx_enable[id]).
  - On drv_rx_enable with a valid id: cl_rx_data[id] <= payload and cl_rx_valid[id] <= 1 next cycle, giving 1-cycle latency.
  - On drv_rx_enable with id>=N_CHAN: the word is dropped, err_drop_cnt increments and saturates at 16'hFFFF, and no cl_rx_valid changes.
  - cl_rx_valid[i] clears after cl_rx_enable[i] unless it is reloaded the same cycle; a simultaneous consume and load leaves valid=1 with new data.
  - cl_rx_enable[i] while cl_rx_valid[i]=0 is ignored.
  - A stalled channel blocks the driver RX stream (head-of-line blocking is accepted by design). TX and RX operate independently.
- N_CHAN=1: the arbiter degenerates to a single FIFO and the id is always 0.

Test Plan:
- Reset release, N_CHAN=4 -> cl_tx_rdy=4'b1111, cl_rx_valid=0, drv_tx_enable=0, err_drop_cnt=0.
- All 4 channels write 3 words each back-to-back (payload = ch*16+n), drv_tx_rdy=1 -> 12 consecutive drv_tx_enable cycles with id order 0,1,2,3,0,1,2,3,0,1,2,3 and per-channel payloads in order.
- Channel 2 pushes 5 words with drv_tx_rdy=0 -> cl_tx_rdy[2]=0 after the 4th accept and the 5th is held. Raise drv_tx_rdy -> 5 words emerge in order with id=2.
- Driver RX words with ids 1,1,3, cl_rx_enable[1]=0 -> word A on ch1 after 1 cycle; drv_rx_enable stalls on the second id-1 word (the id-3 word behind it also waits). Pulse cl_rx_enable[1] -> the second word loads the same cycle, then the id-3 word is delivered.
- RX word with id=7 (N_CHAN=4) -> dequeued, no cl_rx_valid change, err_drop_cnt=1. Force 65536 bad words -> count stays 16'hFFFF.
- Assert reset with 2 words queued on ch0 and cl_rx_valid[3]=1 -> all cleared, pointer=0; post-reset traffic starts arbitration at channel 0.
